// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot encoder/decoder family.
// Provides default widths, the stage state enum, and the index/validity
// functions used by the combinational encoder core. No ports.
package onehot_pkg;

  // Default widths shared with the binary-to-one-hot decoder.
  localparam int ONEHOT_DEF_IN_W  = 8;
  localparam int ONEHOT_DEF_OUT_W = 3;
  localparam int ONEHOT_DEF_CNT_W = 8;

  // Helper functions work on a fixed maximum width; callers zero-extend.
  localparam int ONEHOT_MAX_W = 64;
  localparam int ONEHOT_IDX_W = 6;

  typedef logic [ONEHOT_MAX_W-1:0] onehot_vec_t;
  typedef logic [ONEHOT_IDX_W-1:0] onehot_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  // Scans from the top down so the last hit (lowest index) wins.
  function automatic onehot_idx_t lowest_set_index(onehot_vec_t v);
    onehot_idx_t idx;
    idx = '0;
    for (int i = ONEHOT_MAX_W - 1; i >= 0; i--) begin
      if (v[i]) idx = onehot_idx_t'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit is set (v nonzero and a power of two).
  function automatic logic is_onehot(onehot_vec_t v);
    return (v != '0) && ((v & (v - onehot_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary core: lowest-set-bit index plus malformed flag.
// Ports: vec_i (IN_WIDTH one-hot), idx_o (OUT_WIDTH index), err_o (not one-hot).
// Purely combinational; zero input gives idx_o=0 with err_o=1.
module onehot_to_bin
  import onehot_pkg::*;
#(
  parameter int IN_WIDTH  = ONEHOT_DEF_IN_W,
  parameter int OUT_WIDTH = ONEHOT_DEF_OUT_W
) (
  input  logic [IN_WIDTH-1:0]  vec_i,
  output logic [OUT_WIDTH-1:0] idx_o,
  output logic                 err_o
);

  if (IN_WIDTH > ONEHOT_MAX_W) begin : g_chk_max
    $error("onehot_to_bin: IN_WIDTH exceeds ONEHOT_MAX_W");
  end

  onehot_vec_t vec_ext;
  onehot_idx_t idx_full;

  always_comb begin
    vec_ext               = '0;
    vec_ext[IN_WIDTH-1:0] = vec_i;
  end

  // The index is bounded by the highest input bit, so it never exceeds
  // IN_WIDTH-1 even when IN_WIDTH is not a power of two.
  assign idx_full = lowest_set_index(vec_ext);
  assign idx_o    = OUT_WIDTH'(idx_full);
  assign err_o    = !is_onehot(vec_ext);

endmodule

// File: rtl/onehot_encoder_stage.sv
// Registered one-hot to binary encoder stage with malformed-code counter.
// Ports: in_valid/in_ready/in accept side, out_valid/out_ready/out/out_err
// result side, clr_err/err_count error statistics. Latency 1 cycle, full rate.
module onehot_encoder_stage
  import onehot_pkg::*;
#(
  parameter int IN_WIDTH      = ONEHOT_DEF_IN_W,
  parameter int OUT_WIDTH     = ONEHOT_DEF_OUT_W,
  parameter int ERR_CNT_WIDTH = ONEHOT_DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_WIDTH-1:0]      in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out,
  output logic                     out_err,
  input  logic                     clr_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  if (IN_WIDTH < 2) begin : g_chk_in
    $error("onehot_encoder_stage: IN_WIDTH must be >= 2");
  end
  if (OUT_WIDTH < $clog2(IN_WIDTH)) begin : g_chk_out
    $error("onehot_encoder_stage: OUT_WIDTH too small for IN_WIDTH");
  end
  if (ERR_CNT_WIDTH < 1) begin : g_chk_cnt
    $error("onehot_encoder_stage: ERR_CNT_WIDTH must be >= 1");
  end

  logic [OUT_WIDTH-1:0]     enc_idx;
  logic                     enc_err;
  logic                     accept;
  stage_state_e             state_q;
  logic [OUT_WIDTH-1:0]     out_q;
  logic                     err_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_base;

  onehot_to_bin #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .vec_i (in),
    .idx_o (enc_idx),
    .err_o (enc_err)
  );

  // A held result frees the slot in the same cycle it is taken downstream.
  assign in_ready = (state_q == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q <= ST_FULL;
            out_q   <= enc_idx;
            err_q   <= enc_err;
          end
        end
        ST_FULL: begin
          if (accept) begin
            out_q <= enc_idx;
            err_q <= enc_err;
          end else if (out_ready) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // Clear is applied before counting, so a clear coinciding with an
  // accepted error leaves the count at 1.
  always_comb begin
    cnt_base = clr_err ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (accept && enc_err && (cnt_base != '1)) begin
      cnt_d = cnt_base + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out       = out_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_onehot_encoder_stage.sv
// Scoreboard bench for onehot_encoder_stage (8-bit in, 3-bit out).
// Two instances share stimulus: 8-bit and 2-bit error counters.
// Expected results are queued on accept and compared while presented.
module tb_onehot_encoder_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;
  logic       clr_err;

  logic       in_ready,  in_ready2;
  logic       out_valid, out_valid2;
  logic [2:0] out_idx,   out_idx2;
  logic       out_err,   out_err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  onehot_encoder_stage #(.IN_WIDTH(8), .OUT_WIDTH(3), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in(in_vec), .out_valid(out_valid), .out_ready(out_ready), .out(out_idx),
    .out_err(out_err), .clr_err(clr_err), .err_count(err_count)
  );

  onehot_encoder_stage #(.IN_WIDTH(8), .OUT_WIDTH(3), .ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in(in_vec), .out_valid(out_valid2), .out_ready(out_ready), .out(out_idx2),
    .out_err(out_err2), .clr_err(clr_err), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  // Reference model state.
  logic       m_valid;
  logic [7:0] m_cnt8;
  logic [1:0] m_cnt2;
  logic [2:0] nxt_idx;
  logic       nxt_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model at the
  // rising edge. Inputs and nxt_idx/nxt_err are set by the caller.
  task automatic step();
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    exp_rdy = !m_valid || out_ready;
    acc     = in_valid && exp_rdy;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("out_valid_sat", {31'd0, out_valid2}, {31'd0, m_valid});
    check_eq("err_count", {24'd0, err_count}, {24'd0, m_cnt8});
    check_eq("err_count_sat", {30'd0, err_count2}, {30'd0, m_cnt2});
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        check_eq("out", {29'd0, out_idx}, {29'd0, exp_q[0].idx});
        check_eq("out_err", {31'd0, out_err}, {31'd0, exp_q[0].err});
        check_eq("out_sat", {29'd0, out_idx2}, {29'd0, exp_q[0].idx});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back('{idx: nxt_idx, err: nxt_err});
    @(posedge clk);
    if (acc) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (clr_err) begin
      m_cnt8 = '0;
      m_cnt2 = '0;
    end
    if (acc && nxt_err) begin
      if (m_cnt8 != 8'hff) m_cnt8 = m_cnt8 + 8'd1;
      if (m_cnt2 != 2'h3)  m_cnt2 = m_cnt2 + 2'd1;
    end
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic [2:0] idx, input logic err);
    in_valid = 1'b1;
    in_vec   = v;
    nxt_idx  = idx;
    nxt_err  = err;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
    step();
  endtask

  function automatic exp_t model_enc(input logic [7:0] v);
    exp_t e;
    int   ones;
    e    = '0;
    ones = 0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        e.idx = 3'(i);
        ones++;
      end
    end
    e.err = (ones != 1);
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    n_checks  = 0;
    n_errors  = 0;
    m_valid   = 1'b0;
    m_cnt8    = '0;
    m_cnt2    = '0;
    nxt_idx   = '0;
    nxt_err   = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    clr_err   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out", {29'd0, out_idx}, 32'd0);
    check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
    check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    idle();

    // Basic encode.
    send(8'b0010_0000, 3'd5, 1'b0);
    idle();

    // Malformed codes.
    send(8'h00, 3'd0, 1'b1);
    send(8'b1000_0100, 3'd2, 1'b1);
    idle();
    check_eq("malformed_count", {24'd0, err_count}, 32'd2);

    // Backpressure: second input stalls while the first is held.
    out_ready = 1'b0;
    send(8'h01, 3'd0, 1'b0);
    send(8'h80, 3'd7, 1'b0);
    send(8'h80, 3'd7, 1'b0);
    check_eq("hold_out", {29'd0, out_idx}, 32'd0);
    out_ready = 1'b1;
    send(8'h80, 3'd7, 1'b0);
    check_eq("after_release_out", {29'd0, out_idx}, 32'd7);
    // Back-to-back throughput.
    send(8'h02, 3'd1, 1'b0);
    send(8'h04, 3'd2, 1'b0);
    send(8'h08, 3'd3, 1'b0);
    idle();
    idle();

    // Saturation of the 2-bit counter.
    send(8'h00, 3'd0, 1'b1);
    send(8'h03, 3'd0, 1'b1);
    send(8'hff, 3'd0, 1'b1);
    send(8'h00, 3'd0, 1'b1);
    send(8'h18, 3'd3, 1'b1);
    idle();
    check_eq("sat_count2", {30'd0, err_count2}, 32'd3);

    // Clear coinciding with an error, then clear alone.
    clr_err = 1'b1;
    send(8'h00, 3'd0, 1'b1);
    clr_err = 1'b0;
    idle();
    check_eq("clr_and_err", {24'd0, err_count}, 32'd1);
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    idle();
    check_eq("clr_alone", {24'd0, err_count}, 32'd0);

    // Randomised traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] v;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) v = 8'($urandom);
      else v = 8'(1) << $urandom_range(0, 7);
      clr_err = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 4) != 0) begin
        e = model_enc(v);
        send(v, e.idx, e.err);
      end else begin
        idle();
      end
    end
    clr_err   = 1'b0;
    out_ready = 1'b1;
    idle();
    idle();

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    send(8'h40, 3'd6, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_out", {29'd0, out_idx}, 32'd0);
    m_valid = 1'b0;
    m_cnt8  = '0;
    m_cnt2  = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) idle();
    check_eq("arst_no_stale", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
